fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. Holds the program counter, drives the instruction-memory address, selects the next PC (sequential or redirected by a taken branch/jump resolved in Execute), and registers the fetched word into the Fetch→Decode pipeline register. Its `instr_d` output is the instruction word consumed in Decode by the control unit, the register file and the immediate sign-extension block.

## Interface
Parameters:
- `RESET_PC`, default 32'hBFC0_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall_f`  in  1  hold the PC; from the hazard unit.
- `stall_d`  in  1  hold the F/D register.
- `flush_d`  in  1  replace the F/D contents with a bubble.
- `pcsrc_e`  in  1  taken branch/jump in Execute; redirect the PC.
- `pctarget_e`  in  32  redirect target computed in Execute.
- `imem_addr`  out  32  instruction-memory address; equals `pc_f`.
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr`.
- `instr_d`  out  32  registered instruction for Decode.
- `pc_d`  out  32  PC of `instr_d`.
- `pcplus4_d`  out  32  `pc_d + 4`.
- `valid_d`  out  1  1 = `instr_d` is a real fetched instruction; 0 = bubble.

## Operation
- PC register `pc_f`:
  - `pcplus4_f = pc_f + 4`, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
  - Next PC priority: `rst` > `pcsrc_e` > `stall_f` > sequential.
    - `rst`: load `RESET_PC`.
    - `pcsrc_e=1`: load `{pctarget_e[31:2], 2'b00}`. Bits [1:0] are forced to zero because only word-aligned fetch is supported. The redirect is taken even when `stall_f=1`.
    - `stall_f=1`: hold `pc_f`.
    - Otherwise: load `pcplus4_f`.
- F/D register (`instr_d`, `pc_d`, `pcplus4_d`, `valid_d`):
  - Update priority: `rst` > `flush_d` > `stall_d` > load.
  - `rst` or `flush_d`: `instr_d` = NOP (32'h0000_0013), `pc_d` = 0, `pcplus4_d` = 0, `valid_d` = 0.
  - `stall_d=1`: hold all four outputs.
  - Load: `instr_d = imem_rdata`, `pc_d = pc_f`, `pcplus4_d = pcplus4_f`, `valid_d = 1`.
- No state machine beyond these two registers. The block does not decode the instruction and does not check for an illegal opcode.

## Timing
- Reset values:
  - `pc_f` / `imem_addr` = `RESET_PC`.
  - `instr_d` = 32'h0000_0013, `pc_d` = 0, `pcplus4_d` = 0, `valid_d` = 0.
- Fetch latency: the word at `imem_addr` in cycle N appears on `instr_d` after the rising edge ending cycle N.
  - First valid instruction: one edge after `rst` deasserts, `valid_d=1` with `pc_d = RESET_PC`.
- Redirect: `pcsrc_e` sampled at edge E gives `imem_addr = target` in the cycle after E.
  - The hazard unit asserts `flush_d` in the same cycle as `pcsrc_e`. This discards the wrong-path word that would otherwise load into F/D at edge E.
- Simultaneous events:
  - `flush_d` and `stall_d` together: flush wins, F/D becomes a bubble.
  - `pcsrc_e` and `stall_f` together: redirect wins.
  - `stall_f=1` and `stall_d=0`: F/D reloads the same `pc_f` word. This duplication is legal, and the hazard unit never requests it except together with `flush_d`.
- Reset mid-operation: `rst` overrides every other input on the same edge. No partial state survives.
- `imem_addr` is a direct register output with no combinational path from any input. The only combinational path through the block is `imem_rdata`, which feeds the F/D register input.

## Structure
- Shared package `riscv_pkg`: `XLEN = 32`, `NOP_INSTR = 32'h0000_0013`, `RESET_PC_DEFAULT = 32'hBFC0_0000`.
- Sub-module `fetch_decode_reg`: the F/D register with stall, flush and synchronous reset. It is reused as the template for the later D/E, E/M and M/W registers.
- `fetch_stage` contains the PC register, the +4 adder and the next-PC mux, and instantiates `fetch_decode_reg`.

## Test plan
- Reset then free-run, memory returning the address as data: `instr_d` = 32'hBFC0_0000, 32'hBFC0_0004, ... on consecutive cycles; `valid_d=1` from the first edge after reset; `pcplus4_d` = `pc_d + 4` throughout.
- `pcsrc_e=1`, `pctarget_e=32'h0000_0103`, `flush_d=1` for one cycle: next `imem_addr` = 32'h0000_0100; F/D shows NOP with `valid_d=0` for one cycle, then `pc_d` = 32'h100.
- `stall_f=1`, `stall_d=1` for 3 cycles: `imem_addr`, `instr_d` and `pc_d` are frozen, then sequential fetch resumes with no word skipped.
- `stall_d=1` and `flush_d=1` together: bubble is loaded (`valid_d=0`, `instr_d=32'h13`); `pcsrc_e` with `stall_f=1` → the redirect target is taken.
- PC at 32'hFFFF_FFFC, no stall: next `imem_addr` = 0; assert `rst` mid-run → next cycle `imem_addr` = `RESET_PC` and `valid_d=0`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: widths, constants and pipeline-register payloads.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // Fetch->Decode pipeline payload
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic            valid;
    } fd_payload_t;

    // Bubble inserted on reset or flush: a NOP that Decode ignores via valid=0
    localparam fd_payload_t FD_BUBBLE = '{
        instr:   NOP_INSTR,
        pc:      '0,
        pcplus4: '0,
        valid:   1'b0
    };

    // Only word-aligned fetch is supported, so low address bits are dropped
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_decode_reg.sv
// F/D pipeline register with stall, flush and synchronous reset.
// Template for the later D/E, E/M and M/W registers.
module fetch_decode_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  fd_payload_t data_i,
    output fd_payload_t data_o
);

    fd_payload_t data_q;
    fd_payload_t data_d;

    // Next contents: flush beats stall, stall holds, otherwise load
    always_comb begin
        data_d = data_i;
        if (flush_i) begin
            data_d = FD_BUBBLE;
        end else if (stall_i) begin
            data_d = data_q;
        end
    end

    // Register with reset to a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= FD_BUBBLE;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and F/D register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pcsrc_e,
    input  logic [XLEN-1:0] pctarget_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d
);

    logic [XLEN-1:0] pc_f_q;
    logic [XLEN-1:0] pc_f_d;
    logic [XLEN-1:0] pcplus4_f;
    fd_payload_t     fd_in;
    fd_payload_t     fd_out;

    // Sequential address, wraps modulo 2^32
    assign pcplus4_f = pc_f_q + XLEN'(INSTR_BYTES);

    // Next-PC select: a redirect overrides a fetch stall
    always_comb begin
        pc_f_d = pcplus4_f;
        if (pcsrc_e) begin
            pc_f_d = word_align(pctarget_e);
        end else if (stall_f) begin
            pc_f_d = pc_f_q;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q <= RESET_PC;
        end else begin
            pc_f_q <= pc_f_d;
        end
    end

    // Memory address comes straight from the register, no input-to-output path
    assign imem_addr = pc_f_q;

    assign fd_in = '{
        instr:   imem_rdata,
        pc:      pc_f_q,
        pcplus4: pcplus4_f,
        valid:   1'b1
    };

    fetch_decode_reg u_fd_reg (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall_d),
        .flush_i (flush_d),
        .data_i  (fd_in),
        .data_o  (fd_out)
    );

    assign instr_d   = fd_out.instr;
    assign pc_d      = fd_out.pc;
    assign pcplus4_d = fd_out.pcplus4;
    assign valid_d   = fd_out.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage; memory returns the address as the data word.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall_f, stall_d, flush_d, pcsrc_e;
    logic [31:0] pctarget_e, imem_addr, imem_rdata, instr_d, pc_d, pcplus4_d;
    logic        valid_d;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   step_no = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .pcsrc_e    (pcsrc_e),
        .pctarget_e (pctarget_e),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge
    task automatic step(input logic r, input logic sf, input logic sd, input logic fd,
                        input logic ps, input logic [31:0] tgt,
                        input logic [31:0] e_addr, input logic [31:0] e_instr,
                        input logic [31:0] e_pc, input logic [31:0] e_p4, input logic e_v);
        exp_t e;
        @(negedge clk);
        rst = r; stall_f = sf; stall_d = sd; flush_d = fd; pcsrc_e = ps; pctarget_e = tgt;
        e.addr = e_addr; e.instr = e_instr; e.pc = e_pc; e.pcplus4 = e_p4; e.valid = e_v;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT state shortly after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                step_no++;
                chk("imem_addr", step_no, imem_addr, e.addr);
                chk("instr_d",   step_no, instr_d,   e.instr);
                chk("pc_d",      step_no, pc_d,      e.pc);
                chk("pcplus4_d", step_no, pcplus4_d, e.pcplus4);
                chk("valid_d",   step_no, {31'b0, valid_d}, {31'b0, e.valid});
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pcsrc_e = 1'b0;
        pctarget_e = 32'h0;

        //    rst sf sd fd ps target        addr          instr         pc            pc+4          v
        // reset
        step(1, 0, 0, 0, 0, 32'h0,         32'hBFC00000, 32'h00000013, 32'h0,        32'h0,        0);
        step(1, 0, 0, 0, 0, 32'h0,         32'hBFC00000, 32'h00000013, 32'h0,        32'h0,        0);
        // free run
        step(0, 0, 0, 0, 0, 32'h0,         32'hBFC00004, 32'hBFC00000, 32'hBFC00000, 32'hBFC00004, 1);
        step(0, 0, 0, 0, 0, 32'h0,         32'hBFC00008, 32'hBFC00004, 32'hBFC00004, 32'hBFC00008, 1);
        step(0, 0, 0, 0, 0, 32'h0,         32'hBFC0000C, 32'hBFC00008, 32'hBFC00008, 32'hBFC0000C, 1);
        // redirect to unaligned target with flush
        step(0, 0, 0, 1, 1, 32'h00000103,  32'h00000100, 32'h00000013, 32'h0,        32'h0,        0);
        step(0, 0, 0, 0, 0, 32'h0,         32'h00000104, 32'h00000100, 32'h00000100, 32'h00000104, 1);
        // full stall for three cycles
        step(0, 1, 1, 0, 0, 32'h0,         32'h00000104, 32'h00000100, 32'h00000100, 32'h00000104, 1);
        step(0, 1, 1, 0, 0, 32'h0,         32'h00000104, 32'h00000100, 32'h00000100, 32'h00000104, 1);
        step(0, 1, 1, 0, 0, 32'h0,         32'h00000104, 32'h00000100, 32'h00000100, 32'h00000104, 1);
        step(0, 0, 0, 0, 0, 32'h0,         32'h00000108, 32'h00000104, 32'h00000104, 32'h00000108, 1);
        // flush wins over stall_d
        step(0, 1, 1, 1, 0, 32'h0,         32'h00000108, 32'h00000013, 32'h0,        32'h0,        0);
        // redirect wins over stall_f; F/D loads the current word
        step(0, 1, 0, 0, 1, 32'h00000200,  32'h00000200, 32'h00000108, 32'h00000108, 32'h0000010C, 1);
        step(0, 0, 0, 0, 0, 32'h0,         32'h00000204, 32'h00000200, 32'h00000200, 32'h00000204, 1);
        // wrap at the top of the address space
        step(0, 0, 0, 1, 1, 32'hFFFFFFFC,  32'hFFFFFFFC, 32'h00000013, 32'h0,        32'h0,        0);
        step(0, 0, 0, 0, 0, 32'h0,         32'h00000000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000000, 1);
        step(0, 0, 0, 0, 0, 32'h0,         32'h00000004, 32'h00000000, 32'h00000000, 32'h00000004, 1);
        // stall_f alone: F/D reloads the held word
        step(0, 1, 0, 0, 0, 32'h0,         32'h00000004, 32'h00000004, 32'h00000004, 32'h00000008, 1);
        // reset mid-run overrides redirect and stall
        step(1, 0, 1, 0, 1, 32'h00000300,  32'hBFC00000, 32'h00000013, 32'h0,        32'h0,        0);
        step(0, 0, 0, 0, 0, 32'h0,         32'hBFC00004, 32'hBFC00000, 32'hBFC00000, 32'hBFC00004, 1);

        // let the monitor drain, bounded
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
